// File: rtl/layer_irq_arbiter_if.sv
// ---------------------------------------------------------------------------
// layer_irq_arbiter_if
// Readout request channel between the layer interrupt arbiter (master) and
// the SPI readout sequencer (slave).
//
//   req_valid : master -> slave, a readout request is offered
//   req_layer : master -> slave, layer index of the request
//   req_ready : slave  -> master, sequencer accepts the request
//   done      : slave  -> master, one-cycle pulse, granted layer read out
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high. Once req_valid rises it stays high, and
// req_layer stays constant, until that transfer. The slave may hold
// req_ready low for any number of cycles. After the transfer the slave
// reports completion with a single-cycle done pulse.
// ---------------------------------------------------------------------------
interface layer_irq_arbiter_if #(
    parameter int LW = 5
);
    logic          req_valid;
    logic [LW-1:0] req_layer;
    logic          req_ready;
    logic          done;

    modport master (
        output req_valid,
        output req_layer,
        input  req_ready,
        input  done
    );

    modport slave (
        input  req_valid,
        input  req_layer,
        output req_ready,
        output done
    );
endinterface

// File: rtl/layer_irq_arbiter.sv
// ---------------------------------------------------------------------------
// layer_irq_arbiter
// Collects the active-low layer interrupt lines, synchronises them to
// sysclk and turns them into one readout request at a time, round-robin.
// A service timeout recovers from layers that never report done.
//
// Ports:
//   sysclk            core clock, rising edge
//   warm_resn         asynchronous active-low reset
//   layer_interruptn  asynchronous interrupt lines, active low
//   layer_enable      per-layer arbitration enable (quasi-static)
//   timeout_cycles    service timeout in cycles, 0 disables it
//   readout           request channel (req_valid/req_layer/req_ready/done)
//   busy              registered, high whenever the FSM is not IDLE
//   pending           synchronised and enabled interrupt vector
//   timeout_err       one-cycle pulse when a service times out
//   timeout_count     saturating number of timeouts since reset
//   fsm_state         current FSM state (IDLE=0 GRANT=1 SERVICE=2 RELEASE=3)
// ---------------------------------------------------------------------------
module layer_irq_arbiter #(
    parameter int NLAYERS     = 20,
    parameter int SYNC_STAGES = 2,
    parameter int LW          = $clog2(NLAYERS)
) (
    input  logic                  sysclk,
    input  logic                  warm_resn,
    input  logic [NLAYERS-1:0]    layer_interruptn,
    input  logic [NLAYERS-1:0]    layer_enable,
    input  logic [15:0]           timeout_cycles,
    layer_irq_arbiter_if.master   readout,
    output logic                  busy,
    output logic [NLAYERS-1:0]    pending,
    output logic                  timeout_err,
    output logic [7:0]            timeout_count,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SERVICE = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [NLAYERS-1:0] sync_q [SYNC_STAGES];
    logic [LW-1:0]     last;
    logic [LW-1:0]     winner;
    logic [15:0]       svc_cnt;
    logic [16:0]       svc_cnt_inc;
    logic              timeout_hit;

    assign fsm_state = state;

    // Synchroniser chain; reset to 1 so every line reads as "not interrupting".
    always_ff @(posedge sysclk or negedge warm_resn) begin
        if (!warm_resn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
        end else begin
            sync_q[0] <= layer_interruptn;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign pending = ~sync_q[SYNC_STAGES-1] & layer_enable;

    // Round-robin search from last+1 upward with wrap. The candidate is held
    // one bit wider than LW so last+k never overflows before the wrap.
    always_comb begin
        logic          hit;
        logic [LW:0]   cand;
        winner = '0;
        hit    = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NLAYERS; k++) begin
            cand = {1'b0, last} + (LW+1)'(k);
            if (cand >= (LW+1)'(NLAYERS)) begin
                cand = cand - (LW+1)'(NLAYERS);
            end
            if (!hit && pending[cand[LW-1:0]]) begin
                hit    = 1'b1;
                winner = cand[LW-1:0];
            end
        end
    end

    assign svc_cnt_inc = {1'b0, svc_cnt} + 17'd1;

    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) next_state = GRANT;
            end
            GRANT: begin
                // done is deliberately ignored here; only the handshake moves on.
                if (readout.req_valid && readout.req_ready) next_state = SERVICE;
            end
            SERVICE: begin
                // done takes priority over a coincident timeout.
                if (readout.done) begin
                    next_state = RELEASE;
                end else if (timeout_cycles != 16'd0 &&
                             svc_cnt_inc == {1'b0, timeout_cycles}) begin
                    next_state  = RELEASE;
                    timeout_hit = 1'b1;
                end
            end
            RELEASE: begin
                // One idle cycle so the served line can deassert.
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge warm_resn) begin
        if (!warm_resn) begin
            state             <= IDLE;
            last              <= LW'(NLAYERS-1);
            readout.req_valid <= 1'b0;
            readout.req_layer <= '0;
            busy              <= 1'b0;
            svc_cnt           <= '0;
            timeout_err       <= 1'b0;
            timeout_count     <= '0;
        end else begin
            state             <= next_state;
            readout.req_valid <= (next_state == GRANT);
            busy              <= (next_state != IDLE);
            timeout_err       <= timeout_hit;

            if (state == IDLE && next_state == GRANT) begin
                readout.req_layer <= winner;
                last              <= winner;
            end

            if (state == GRANT) begin
                svc_cnt <= '0;
            end else if (state == SERVICE) begin
                svc_cnt <= svc_cnt + 16'd1;
            end

            if (timeout_hit && timeout_count != 8'hFF) begin
                timeout_count <= timeout_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_layer_irq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_layer_irq_arbiter
// Directed bench for layer_irq_arbiter: a table of single-grant vectors
// followed by hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_layer_irq_arbiter;

    localparam int NL = 20;
    localparam int LWB = 5;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            warm_resn;
    logic [NL-1:0]   layer_interruptn;
    logic [NL-1:0]   layer_enable;
    logic [15:0]     timeout_cycles;
    logic            busy;
    logic [NL-1:0]   pending;
    logic            timeout_err;
    logic [7:0]      timeout_count;
    logic [1:0]      fsm_state;

    always #5 clk = ~clk;

    layer_irq_arbiter_if #(.LW(LWB)) rd ();

    layer_irq_arbiter #(.NLAYERS(NL), .SYNC_STAGES(2), .LW(LWB)) dut (
        .sysclk           (clk),
        .warm_resn        (warm_resn),
        .layer_interruptn (layer_interruptn),
        .layer_enable     (layer_enable),
        .timeout_cycles   (timeout_cycles),
        .readout          (rd.master),
        .busy             (busy),
        .pending          (pending),
        .timeout_err      (timeout_err),
        .timeout_count    (timeout_count),
        .fsm_state        (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [LWB-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        warm_resn = 1'b0;
        repeat (2) tick();
        warm_resn = 1'b1;
    endtask

    // Waits (bounded) until req_valid is seen at a falling edge.
    task automatic wait_req(input int limit, output logic got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rd.req_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) got = rd.req_valid;
    endtask

    task automatic pulse_done();
        rd.done = 1'b1;
        tick();
        rd.done = 1'b0;
    endtask

    // Wait for a grant and compare its layer with the head of exp_q.
    task automatic expect_grant(input string name);
        logic got;
        logic [LWB-1:0] exp;
        wait_req(20, got);
        check({name, "_seen"}, 32'(got), 32'd1);
        exp = exp_q.pop_front();
        check({name, "_layer"}, 32'(rd.req_layer), 32'(exp));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string         name;
        logic [NL-1:0] low;
        logic [NL-1:0] en;
        logic          exp_req;
        logic [LWB-1:0] exp_layer;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic got;
        int first_hit;
        int highs;
        int pulses;
        logic [1:0] state_at_hit;
        logic [7:0] count_at_hit;

        vecs[0] = '{"single9",     20'h00200, 20'hFFFFF,  1'b1, 5'd9};
        vecs[1] = '{"masked9",     20'h00200, ~20'h00200, 1'b0, 5'd0};
        vecs[2] = '{"pair3_17",    20'h20008, 20'hFFFFF,  1'b1, 5'd3};
        vecs[3] = '{"only19",      20'h80000, 20'hFFFFF,  1'b1, 5'd19};
        vecs[4] = '{"zero_19",     20'h80001, 20'hFFFFF,  1'b1, 5'd0};
        vecs[5] = '{"all_en11_13", 20'hFFFFF, 20'h02800,  1'b1, 5'd11};
        vecs[6] = '{"none_en",     20'h00040, 20'h00000,  1'b0, 5'd0};
        vecs[7] = '{"idle_quiet",  20'h00000, 20'hFFFFF,  1'b0, 5'd0};
        vecs[8] = '{"mask2_get18", 20'h40004, ~20'h00004, 1'b1, 5'd18};

        layer_interruptn = '1;
        layer_enable     = '1;
        timeout_cycles   = 16'd0;
        rd.req_ready     = 1'b1;
        rd.done          = 1'b0;
        warm_resn        = 1'b0;

        // ---- reset values while held in reset ----
        tick();
        tick();
        check("rst_req_valid",  32'(rd.req_valid),   32'd0);
        check("rst_req_layer",  32'(rd.req_layer),   32'd0);
        check("rst_busy",       32'(busy),           32'd0);
        check("rst_pending",    32'(pending),        32'd0);
        check("rst_timeout",    32'(timeout_err),    32'd0);
        check("rst_tcount",     32'(timeout_count),  32'd0);
        check("rst_state",      32'(fsm_state),      32'(S_IDLE));
        warm_resn = 1'b1;

        // ---- table: first grant after reset ----
        for (int i = 0; i < 9; i++) begin
            layer_interruptn = ~vecs[i].low;
            layer_enable     = vecs[i].en;
            rd.req_ready     = 1'b0;
            apply_reset();
            wait_req(8, got);
            check({vecs[i].name, "_req"}, 32'(got), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) begin
                check({vecs[i].name, "_layer"}, 32'(rd.req_layer), 32'(vecs[i].exp_layer));
            end
            check({vecs[i].name, "_pending"}, 32'(pending), 32'(vecs[i].low & vecs[i].en));
        end

        // ---- single layer latency and return to idle ----
        layer_interruptn = '1;
        layer_enable     = '1;
        rd.req_ready     = 1'b1;
        apply_reset();
        layer_interruptn[5] = 1'b0;
        tick();
        check("lat_pending_e1", 32'(pending), 32'd0);
        tick();
        check("lat_pending_e2", 32'(pending), 32'h00020);
        check("lat_valid_e2",   32'(rd.req_valid), 32'd0);
        tick();
        check("lat_valid_e3",   32'(rd.req_valid), 32'd1);
        check("lat_layer_e3",   32'(rd.req_layer), 32'd5);
        check("lat_busy_e3",    32'(busy), 32'd1);
        tick();
        check("lat_state_svc",  32'(fsm_state), 32'(S_SERVICE));
        check("lat_valid_svc",  32'(rd.req_valid), 32'd0);
        layer_interruptn[5] = 1'b1;
        pulse_done();
        check("lat_state_rel",  32'(fsm_state), 32'(S_RELEASE));
        tick();
        check("lat_busy_idle",  32'(busy), 32'd0);
        repeat (6) tick();
        check("lat_no_rereq",   32'(rd.req_valid), 32'd0);
        check("lat_state_idle", 32'(fsm_state), 32'(S_IDLE));

        // ---- simultaneous layers 3 and 17: fair alternation ----
        layer_interruptn = '1;
        layer_interruptn[3]  = 1'b0;
        layer_interruptn[17] = 1'b0;
        apply_reset();
        for (int g = 0; g < 6; g++) exp_q.push_back((g % 2 == 0) ? 5'd3 : 5'd17);
        for (int g = 0; g < 6; g++) begin
            expect_grant("sim");
            tick();
            repeat (9) tick();
            pulse_done();
        end

        // ---- wrap-around after 19 ----
        layer_interruptn = '1;
        layer_interruptn[19] = 1'b0;
        apply_reset();
        exp_q.push_back(5'd19);
        expect_grant("wrap_a");
        tick();
        layer_interruptn = '1;
        layer_interruptn[0]  = 1'b0;
        layer_interruptn[18] = 1'b0;
        repeat (4) tick();
        pulse_done();
        exp_q.push_back(5'd0);
        expect_grant("wrap_b");
        tick();
        repeat (3) tick();
        pulse_done();
        exp_q.push_back(5'd18);
        expect_grant("wrap_c");

        // ---- backpressure: request held while layer 7 toggles ----
        layer_interruptn = '1;
        layer_interruptn[7] = 1'b0;
        rd.req_ready = 1'b0;
        apply_reset();
        exp_q.push_back(5'd7);
        expect_grant("bp");
        for (int i = 0; i < 20; i++) begin
            layer_interruptn[7] = 1'($urandom_range(0, 1));
            layer_enable[7]     = 1'($urandom_range(0, 1));
            rd.done             = (i == 10);
            tick();
            check("bp_valid", 32'(rd.req_valid), 32'd1);
            check("bp_layer", 32'(rd.req_layer), 32'd7);
            check("bp_state", 32'(fsm_state),    32'(S_GRANT));
        end
        rd.done          = 1'b0;
        layer_interruptn = '1;
        layer_enable     = '1;
        rd.req_ready     = 1'b1;
        tick();
        check("bp_xfer_state", 32'(fsm_state),    32'(S_SERVICE));
        check("bp_xfer_valid", 32'(rd.req_valid), 32'd0);

        // ---- done coinciding with the timeout wins, no error ----
        timeout_cycles = 16'd50;
        layer_interruptn = '1;
        layer_interruptn[2] = 1'b0;
        apply_reset();
        wait_req(10, got);
        check("tc_grant", 32'(got), 32'd1);
        tick();
        repeat (49) tick();
        rd.done = 1'b1;
        tick();
        rd.done = 1'b0;
        check("tc_state",  32'(fsm_state),     32'(S_RELEASE));
        check("tc_err",    32'(timeout_err),   32'd0);
        check("tc_count",  32'(timeout_count), 32'd0);

        // ---- timeout 50 cycles after entering SERVICE ----
        wait_req(10, got);
        check("to_grant", 32'(got), 32'd1);
        tick();
        first_hit = 0;
        highs = 0;
        state_at_hit = S_IDLE;
        count_at_hit = 8'd0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (timeout_err) begin
                highs++;
                if (first_hit == 0) begin
                    first_hit    = c;
                    state_at_hit = fsm_state;
                    count_at_hit = timeout_count;
                end
            end
        end
        check("to_cycle",     32'(first_hit),    32'd50);
        check("to_pulses",    32'(highs),        32'd1);
        check("to_state",     32'(state_at_hit), 32'(S_RELEASE));
        check("to_count_1",   32'(count_at_hit), 32'd1);

        // ---- saturation of timeout_count ----
        pulse_done();
        timeout_cycles = 16'd2;
        pulses = 0;
        for (int i = 0; i < 5000 && pulses < 300; i++) begin
            tick();
            if (timeout_err) pulses++;
        end
        check("sat_pulses", 32'(pulses),        32'd300);
        check("sat_count",  32'(timeout_count), 32'd255);

        // ---- timeout disabled: no error over 70000 cycles ----
        layer_interruptn = '1;
        repeat (10) tick();
        check("dis_idle", 32'(fsm_state), 32'(S_IDLE));
        timeout_cycles = 16'd0;
        layer_interruptn[2] = 1'b0;
        wait_req(10, got);
        check("dis_grant", 32'(got), 32'd1);
        tick();
        pulses = 0;
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (timeout_err) pulses++;
        end
        check("dis_pulses", 32'(pulses),        32'd0);
        check("dis_state",  32'(fsm_state),     32'(S_SERVICE));
        check("dis_count",  32'(timeout_count), 32'd255);

        // ---- asynchronous reset mid-SERVICE ----
        layer_interruptn[15] = 1'b0;
        repeat (3) tick();
        #2 warm_resn = 1'b0;
        #1;
        check("ar_req_valid", 32'(rd.req_valid),  32'd0);
        check("ar_req_layer", 32'(rd.req_layer),  32'd0);
        check("ar_busy",      32'(busy),          32'd0);
        check("ar_pending",   32'(pending),       32'd0);
        check("ar_timeout",   32'(timeout_err),   32'd0);
        check("ar_tcount",    32'(timeout_count), 32'd0);
        check("ar_state",     32'(fsm_state),     32'(S_IDLE));
        @(negedge clk);
        warm_resn = 1'b1;
        exp_q.push_back(5'd2);
        expect_grant("ar_first");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer_irq_arbiter.md
# layer_irq_arbiter

Round-robin arbiter that collects the 20 active-low layer interrupt lines from the row/layer chips and serialises them into readout requests for the downstream readout engine. It sits between the `layerN_interruptn` pins and the SPI readout sequencer inside the core, on the `sysclk` domain. It grants exactly one layer at a time and waits for that layer's readout to finish. A timeout recovers from layers that never complete.

## Interface
- `NLAYERS`, 20, number of interrupt inputs (2..32)
- `SYNC_STAGES`, 2, synchroniser flops per interrupt line (≥2)
- `LW`, $clog2(NLAYERS), width of layer index
- `sysclk`  in  1  core clock; all logic on rising edge
- `warm_resn`  in  1  asynchronous active-low reset
- `layer_interruptn`  in  NLAYERS  asynchronous interrupt lines, active low (bit i = layer i)
- `layer_enable`  in  NLAYERS  per-layer arbitration enable, quasi-static register
- `timeout_cycles`  in  16  service timeout in cycles; 0 disables timeout
- `req_valid`  out  1  readout request valid
- `req_layer`  out  LW  layer index of request, stable while `req_valid`
- `req_ready`  in  1  readout engine accepts request
- `done`  in  1  single-cycle pulse: readout of granted layer finished
- `busy`  out  1  high in any state other than IDLE
- `pending`  out  NLAYERS  synchronised, enabled interrupt vector
- `timeout_err`  out  1  one-cycle pulse on service timeout
- `timeout_count`  out  8  saturating count of timeouts since reset

## Operation
- Each `layer_interruptn[i]` passes through a SYNC_STAGES flop chain whose reset value is 1. `pending[i]` = ~synced[i] & `layer_enable[i]`.
- Round-robin pointer `last` (LW bits) holds the last granted index. The search starts at `last`+1, ascends, and wraps from NLAYERS-1 to 0. The first set `pending` bit wins. On reset `last` = NLAYERS-1, so layer 0 has first priority.
- FSM states: IDLE, GRANT, SERVICE, RELEASE.
  - IDLE: `pending`≠0 → GRANT. The winner is latched into `req_layer` and `last`, and `req_valid`=1.
  - GRANT: `req_valid` is held and `req_layer` is frozen. The transfer happens in the cycle where `req_valid` & `req_ready` are both high → SERVICE, and the timeout counter is cleared.
    - The request is never retracted, even if the layer's interrupt or enable drops.
    - `done` is ignored in GRANT.
  - SERVICE: `req_valid`=0 and the 16-bit counter increments each cycle.
    - `done` → RELEASE.
    - Else if `timeout_cycles`≠0 and counter+1 == `timeout_cycles` → RELEASE. In that case `timeout_err` pulses in the same cycle as the transition, and `timeout_count` increments, saturating at 255.
    - If `done` and timeout coincide, `done` wins and no error is raised.
  - RELEASE: lasts exactly one cycle with no grant, giving the interrupt line time to deassert → IDLE.
- A layer whose interrupt stays low is re-granted only after every other pending layer has been served once (fairness).

## Timing
- Reset values: `req_valid`=0, `req_layer`=0, `busy`=0, `pending`=0, `timeout_err`=0, `timeout_count`=0, FSM=IDLE, `last`=NLAYERS-1.
- Assertion of `warm_resn` low takes effect immediately in any state, including mid-GRANT or mid-SERVICE. After release the block starts from IDLE.
- Latency: interrupt low at edge 0 → `pending` high after SYNC_STAGES edges → `req_valid` high one edge later (3 cycles with default).
- Handshake: GRANT→SERVICE on the edge where both are sampled high. The minimum grant-to-grant spacing is 4 cycles (GRANT, SERVICE, RELEASE, IDLE).
- Timeout: with `timeout_cycles`=N, the transition occurs N cycles after entering SERVICE.
- `busy` = (state≠IDLE), registered.

## Test plan
- Single layer: `layer_interruptn[5]` low, `req_ready`=1 → `req_valid` at cycle 3 with `req_layer`=5. After `done`, the FSM returns to IDLE; release the interrupt, and no further request follows.
- Simultaneous: layers 3 and 17 low from reset, with `done` 10 cycles after each grant → grants in order 3, 17, 3, 17, …
- Wrap-around: after serving 19, layers 0 and 18 pending → next grant 0, then 18.
- Backpressure: hold `req_ready`=0 for 20 cycles while toggling layer 7's interrupt and enable → `req_valid` stays high and `req_layer` stays constant throughout, then a transfer occurs on the first ready cycle.
- Timeout: `timeout_cycles`=50 and no `done` → `timeout_err` pulses 50 cycles after entering SERVICE and `timeout_count`=1. Repeat 300 times → count saturates at 255. With `timeout_cycles`=0 → no timeout after 70000 cycles.
- Masking and reset: layer 9 low with `layer_enable[9]`=0 → no request and `pending[9]`=0. Assert `warm_resn` mid-SERVICE → all outputs reach their reset values, and the first grant after release is the lowest pending index.
